// File: rtl/jac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jac_pkg
//  Description : Shared widths, opcode constants and fetch state encoding
//                for the Jac1-8 core.
//  Revision    : 1.0 - initial release
// ============================================================================
package jac_pkg;

    localparam int PC_WIDTH          = 8;
    localparam int PROGRAM_DataWidth = 16;
    localparam int NumOpCodeBits     = 5;

    // Opcodes shared with the decoder (upper bits of the instruction word).
    localparam logic [NumOpCodeBits-1:0] OP_NOP   = 5'h00;
    localparam logic [NumOpCodeBits-1:0] OP_LOAD  = 5'h01;
    localparam logic [NumOpCodeBits-1:0] OP_STORE = 5'h02;
    localparam logic [NumOpCodeBits-1:0] OP_ADD   = 5'h03;
    localparam logic [NumOpCodeBits-1:0] OP_SUB   = 5'h04;
    localparam logic [NumOpCodeBits-1:0] OP_GOTO  = 5'h08;
    localparam logic [NumOpCodeBits-1:0] OP_BRREL = 5'h09;
    localparam logic [NumOpCodeBits-1:0] OP_BRZ   = 5'h0A;

    // Fetch unit control states.
    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_skid.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_skid
//  Description : One-entry instruction+pc skid register. Flush beats load,
//                load beats drain.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              drain_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [PC_W-1:0]   pc_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [PC_W-1:0]   pc_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [PC_W-1:0]   pc_q, pc_d;

    // Next-state selection for the single entry.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            pc_d    = pc_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    // Entry storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign pc_o    = pc_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Jac1-8 instruction fetch: program counter, synchronous
//                program-memory reads, registered instruction output with
//                branch redirect/squash and a one-entry stall skid buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int PC_WIDTH          = jac_pkg::PC_WIDTH,
    parameter int PROGRAM_DataWidth = jac_pkg::PROGRAM_DataWidth
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [PC_WIDTH-1:0]          mem_addr,
    output logic                         mem_rd_en,
    input  logic [PROGRAM_DataWidth-1:0] mem_data,
    output logic [PROGRAM_DataWidth-1:0] instruction,
    output logic [PC_WIDTH-1:0]          instr_pc,
    output logic                         instr_valid,
    input  logic                         stall,
    input  logic                         cnt_wr_en,
    input  logic                         add_offset,
    input  logic [PC_WIDTH-1:0]          literal_adr
);
    import jac_pkg::*;

    fetch_state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]          fetch_pc_q, fetch_pc_d;
    logic                         flight_valid_q, flight_valid_d;
    logic [PC_WIDTH-1:0]          flight_pc_q, flight_pc_d;
    logic [PROGRAM_DataWidth-1:0] ir_q, ir_d;
    logic [PC_WIDTH-1:0]          ir_pc_q, ir_pc_d;
    logic                         ir_valid_q, ir_valid_d;

    logic                         skid_valid;
    logic [PROGRAM_DataWidth-1:0] skid_data;
    logic [PC_WIDTH-1:0]          skid_pc;
    logic                         skid_load, skid_drain, skid_flush;

    logic                         req;
    logic                         branch_taken;
    logic [PC_WIDTH-1:0]          branch_target;

    // A request is suppressed while held, stalled, or while the skid still
    // owns an undelivered instruction; this is what bounds the skid to one.
    assign req          = !reset && (state_q != HOLD) && !stall && !skid_valid;
    assign branch_taken = cnt_wr_en && ir_valid_q && !stall;
    assign branch_target = add_offset ? (ir_pc_q + literal_adr) : literal_adr;

    fetch_skid #(
        .DATA_W (PROGRAM_DataWidth),
        .PC_W   (PC_WIDTH)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .flush_i (skid_flush),
        .data_i  (mem_data),
        .pc_i    (flight_pc_q),
        .valid_o (skid_valid),
        .data_o  (skid_data),
        .pc_o    (skid_pc)
    );

    // Next-state: request issue, data steering, branch redirect, FSM.
    always_comb begin
        fetch_pc_d     = fetch_pc_q;
        flight_valid_d = 1'b0;
        flight_pc_d    = flight_pc_q;
        ir_d           = ir_q;
        ir_pc_d        = ir_pc_q;
        ir_valid_d     = ir_valid_q;
        skid_load      = 1'b0;
        skid_drain     = 1'b0;
        skid_flush     = 1'b0;
        state_d        = state_q;

        if (req) begin
            flight_valid_d = 1'b1;
            flight_pc_d    = fetch_pc_q;
            fetch_pc_d     = fetch_pc_q + PC_WIDTH'(1);
        end

        // IR advances whenever downstream accepts; skid content is older
        // than anything in flight so it is delivered first.
        if (!stall) begin
            if (skid_valid) begin
                ir_d       = skid_data;
                ir_pc_d    = skid_pc;
                ir_valid_d = 1'b1;
                skid_drain = 1'b1;
                skid_load  = flight_valid_q;
            end else if (flight_valid_q) begin
                ir_d       = mem_data;
                ir_pc_d    = flight_pc_q;
                ir_valid_d = 1'b1;
            end else begin
                ir_valid_d = 1'b0;
            end
        end else if (flight_valid_q) begin
            skid_load = 1'b1;
        end

        // Redirect squashes everything younger than the branch; the IR word
        // itself is left in place and qualified off by ir_valid.
        if (branch_taken) begin
            fetch_pc_d     = branch_target;
            flight_valid_d = 1'b0;
            skid_flush     = 1'b1;
            skid_load      = 1'b0;
            skid_drain     = 1'b0;
            ir_d           = ir_q;
            ir_pc_d        = ir_pc_q;
            ir_valid_d     = 1'b0;
        end

        case (state_q)
            FILL:    if (ir_valid_d) state_d = RUN;
            RUN:     if (stall && ir_valid_q) state_d = HOLD;
            HOLD:    if (!stall) state_d = RUN;
            default: state_d = FILL;
        endcase
        if (branch_taken) begin
            state_d = FILL;
        end
    end

    // Fetch pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= FILL;
            fetch_pc_q     <= '0;
            flight_valid_q <= 1'b0;
            flight_pc_q    <= '0;
            ir_q           <= '0;
            ir_pc_q        <= '0;
            ir_valid_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            fetch_pc_q     <= fetch_pc_d;
            flight_valid_q <= flight_valid_d;
            flight_pc_q    <= flight_pc_d;
            ir_q           <= ir_d;
            ir_pc_q        <= ir_pc_d;
            ir_valid_q     <= ir_valid_d;
        end
    end

    assign mem_addr    = fetch_pc_q;
    assign mem_rd_en   = req;
    assign instruction = ir_q;
    assign instr_pc    = ir_pc_q;
    assign instr_valid = ir_valid_q;

endmodule
`default_nettype wire
